// File: rtl/serial_add.sv
// serial_add: bit-serial adder computing a + b + cin, LSB first, one full-adder cell per clock.
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_ps;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s, w_maj;
  logic [WIDTH:0]   w_cat;
  assign w_s   = r_a[0] ^ r_b[0] ^ r_c;
  assign w_maj = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  // New sum bit enters at the MSB; slicing the concatenation keeps WIDTH=1 legal.
  assign w_cat = {w_s, r_ps};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ps    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_c     <= cin;
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_maj;
          r_ps  <= w_cat[WIDTH:1];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            sum     <= w_cat[WIDTH:1];
            cout    <= w_maj;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
